// File: rtl/seq_scan_if.sv
// Word-stream handshake between the upstream word source and seq_scan_ctrl.
//   in_valid  master -> slave  in_data/in_last valid
//   in_data   master -> slave  word to scan, shifted MSB first
//   in_last   master -> slave  word is the last of its frame
//   in_ready  slave -> master  controller can accept a word
interface seq_scan_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Frame-level controller for the bit-serial pattern detector.
// Accepts words over a valid/ready handshake, shifts each word MSB first through a
// PAT_W-bit history, pulses match_pulse per detected pattern and counts matches per frame.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   cfg_pattern   pattern, bit PAT_W-1 expected first (latched on a frame's first word)
//   cfg_overlap   1 = overlapping matches allowed (latched on a frame's first word)
//   in_if         word stream (slave side): in_valid/in_data/in_last in, in_ready out
//   match_pulse   one-cycle pulse per match
//   match_count   saturating match count for the current frame
//   frame_done    one-cycle pulse after the last word; match_count is final here
module seq_scan_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PAT_W  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    seq_scan_if.slave        in_if,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             frame_done
);

    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              overlap_q, overlap_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              frame_open_q, frame_open_d;
    logic              match_q, match_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              accept;
    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill_next;
    logic              hit;

    assign in_if.in_ready = (state_q == ST_IDLE);
    assign accept         = in_if.in_valid && in_if.in_ready;

    // Candidate history after shifting in the current MSB; only committed in SHIFT.
    assign hist_next = {hist_q[PAT_W-2:0], word_q[DATA_W-1]};
    assign fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    assign hit       = (fill_next == FILL_FULL) && (hist_next == pat_q);

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        last_d       = last_q;
        bit_cnt_d    = bit_cnt_q;
        pat_d        = pat_q;
        overlap_d    = overlap_q;
        hist_d       = hist_q;
        fill_d       = fill_q;
        frame_open_d = frame_open_q;
        match_d      = 1'b0;
        count_d      = count_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_d       = in_if.in_data;
                    last_d       = in_if.in_last;
                    bit_cnt_d    = '0;
                    frame_open_d = 1'b1;
                    state_d      = ST_SHIFT;
                    // First word of a frame: snapshot config and start a fresh count.
                    if (!frame_open_q) begin
                        pat_d     = cfg_pattern;
                        overlap_d = cfg_overlap;
                        count_d   = '0;
                        hist_d    = '0;
                        fill_d    = '0;
                    end
                end
            end
            ST_SHIFT: begin
                word_d  = word_q << 1;
                hist_d  = hist_next;
                // Without overlap, emptying the fill forces a full fresh pattern next.
                fill_d  = (hit && !overlap_q) ? '0 : fill_next;
                match_d = hit;
                if (hit && (count_q != '1)) begin
                    count_d = count_q + 1'b1;
                end
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = last_q ? ST_DONE : ST_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                frame_open_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            last_q       <= 1'b0;
            bit_cnt_q    <= '0;
            pat_q        <= '0;
            overlap_q    <= 1'b0;
            hist_q       <= '0;
            fill_q       <= '0;
            frame_open_q <= 1'b0;
            match_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            last_q       <= last_d;
            bit_cnt_q    <= bit_cnt_d;
            pat_q        <= pat_d;
            overlap_q    <= overlap_d;
            hist_q       <= hist_d;
            fill_q       <= fill_d;
            frame_open_q <= frame_open_d;
            match_q      <= match_d;
            count_q      <= count_d;
        end
    end

    assign match_pulse = match_q;
    assign match_count = count_q;
    assign frame_done  = (state_q == ST_DONE);

endmodule
